// File: rtl/led_chase_gen.sv
// LED chase generator: prescaled position stepper with bounce, wrap and bar patterns.
// Optional dim trail on the previous position when LED_CHASE_TRAIL_EN is defined.
module led_chase_gen #(
    parameter int NUM_LEDS   = 8,
    parameter int BASE_SHIFT = 18,
    parameter int POS_W      = $clog2(NUM_LEDS)
) (
    input  logic                clk_25mhz,
    input  logic                rst_n,
    input  logic                run,
    input  logic                step,
    input  logic [2:0]          speed,
    input  logic [1:0]          mode,
    output logic [NUM_LEDS-1:0] led,
    output logic                tick,
    output logic [POS_W-1:0]    pos_o
);

    localparam int CNT_W = BASE_SHIFT + 8;
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(NUM_LEDS - 1);

    localparam logic [1:0] MODE_BOUNCE  = 2'd0;
    localparam logic [1:0] MODE_WRAP_UP = 2'd1;
    localparam logic [1:0] MODE_WRAP_DN = 2'd2;
    localparam logic [1:0] MODE_BAR     = 2'd3;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [CNT_W-1:0]    cnt_reg;
    logic [CNT_W-1:0]    cnt_next;
    logic [CNT_W-1:0]    term;
    logic                adv;
    dir_t                dir_reg;
    dir_t                dir_next;
    logic [POS_W-1:0]    pos_reg;
    logic [POS_W-1:0]    pos_next;
    logic [NUM_LEDS-1:0] led_reg;
    logic [NUM_LEDS-1:0] led_next;
    logic                tick_reg;

    // Prescaler: >= compare lets a speed decrease mid-count wrap immediately
    always_comb begin
        term     = (CNT_W'(1) << (BASE_SHIFT + int'(speed))) - CNT_W'(1);
        cnt_next = cnt_reg;
        adv      = 1'b0;
        if (run) begin
            if (cnt_reg >= term) begin
                cnt_next = '0;
                adv      = 1'b1;
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end else begin
            adv = step;
        end
    end

    // State register: direction plus position datapath
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg  <= '0;
            dir_reg  <= DIR_UP;
            pos_reg  <= '0;
            led_reg  <= '0;
            tick_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            dir_reg  <= dir_next;
            pos_reg  <= pos_next;
            led_reg  <= led_next;
            tick_reg <= adv;
        end
    end

    // Next-state logic; the mode sampled on the advance cycle decides the move
    always_comb begin
        dir_next = dir_reg;
        pos_next = pos_reg;
        if (adv) begin
            case (mode)
                MODE_WRAP_UP: begin
                    dir_next = DIR_UP;
                    pos_next = (pos_reg == POS_MAX) ? '0 : pos_reg + POS_W'(1);
                end
                MODE_WRAP_DN: begin
                    dir_next = DIR_DOWN;
                    pos_next = (pos_reg == '0) ? POS_MAX : pos_reg - POS_W'(1);
                end
                default: begin
                    if (dir_reg == DIR_UP) begin
                        if (pos_reg == POS_MAX) begin
                            dir_next = DIR_DOWN;
                            pos_next = pos_reg - POS_W'(1);
                        end else begin
                            pos_next = pos_reg + POS_W'(1);
                        end
                    end else begin
                        if (pos_reg == '0) begin
                            dir_next = DIR_UP;
                            pos_next = pos_reg + POS_W'(1);
                        end else begin
                            pos_next = pos_reg - POS_W'(1);
                        end
                    end
                end
            endcase
        end
    end

`ifdef LED_CHASE_TRAIL_EN
    logic [POS_W-1:0] prev_pos_reg;
    logic             trail_on;

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            prev_pos_reg <= '0;
        end else if (adv) begin
            prev_pos_reg <= pos_reg;
        end
    end

    // Trail lights one cycle in four for a 25% duty dim level
    assign trail_on = (mode != MODE_BAR) && (prev_pos_reg != pos_reg) &&
                      (cnt_reg[1:0] == 2'b00);
`endif

    // Output decode, registered into led_reg one cycle behind pos
    generate
        for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_led
            logic one_hot;
            logic bar;
            assign one_hot = (pos_reg == POS_W'(gi));
            assign bar     = (POS_W'(gi) <= pos_reg);
`ifdef LED_CHASE_TRAIL_EN
            assign led_next[gi] = (mode == MODE_BAR) ? bar :
                                  (one_hot || (trail_on && (prev_pos_reg == POS_W'(gi))));
`else
            assign led_next[gi] = (mode == MODE_BAR) ? bar : one_hot;
`endif
        end
    endgenerate

    assign led   = led_reg;
    assign tick  = tick_reg;
    assign pos_o = pos_reg;

endmodule

// File: tb/tb_led_chase_gen.sv
// Randomized self-checking bench for led_chase_gen against a cycle-level arithmetic model.
module tb_led_chase_gen;

    localparam int N  = 8;
    localparam int BS = 2;

    logic       clk_25mhz = 1'b0;
    logic       rst_n     = 1'b0;
    logic       run       = 1'b0;
    logic       step      = 1'b0;
    logic [2:0] speed     = 3'd0;
    logic [1:0] mode      = 2'd0;
    logic [N-1:0] led;
    logic         tick;
    logic [2:0]   pos_o;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int         m_cnt, m_pos, m_dir, m_prev;
    logic [N-1:0] m_led;
    logic         m_tick;

    always #5 clk_25mhz = ~clk_25mhz;

    led_chase_gen #(.NUM_LEDS(N), .BASE_SHIFT(BS)) dut (
        .clk_25mhz(clk_25mhz),
        .rst_n    (rst_n),
        .run      (run),
        .step     (step),
        .speed    (speed),
        .mode     (mode),
        .led      (led),
        .tick     (tick),
        .pos_o    (pos_o)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_pos = 0; m_dir = 1; m_prev = 0;
        m_led = '0; m_tick = 1'b0;
    endtask

    function automatic logic [N-1:0] led_model(input int p, input int md, input int pp, input int c);
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            if (md == 3) v[i] = (i <= p);
            else         v[i] = (i == p);
        end
`ifdef LED_CHASE_TRAIL_EN
        if (md != 3 && pp != p && (c % 4) == 0) v[pp] = 1'b1;
`endif
        return v;
    endfunction

    task automatic model_clock();
        int  term;
        bit  adv;
        term  = (1 << (BS + int'(speed))) - 1;
        m_led = led_model(m_pos, int'(mode), m_prev, m_cnt);
        if (run) begin
            adv   = (m_cnt >= term);
            m_cnt = adv ? 0 : m_cnt + 1;
        end else begin
            adv = step;
        end
        m_tick = adv;
        if (adv) begin
            m_prev = m_pos;
            case (int'(mode))
                1: begin m_dir = 1;  m_pos = (m_pos + 1) % N;     end
                2: begin m_dir = -1; m_pos = (m_pos + N - 1) % N; end
                default: begin
                    if (m_pos + m_dir < 0 || m_pos + m_dir > N - 1) m_dir = -m_dir;
                    m_pos = m_pos + m_dir;
                end
            endcase
        end
    endtask

    task automatic check_outputs();
        check_val("led", 32'(led), 32'(m_led));
        check_val("tick", 32'(tick), 32'(m_tick));
        check_val("pos_o", 32'(pos_o), 32'(m_pos));
    endtask

    task automatic cycle(input logic r, input logic s, input logic [2:0] sp, input logic [1:0] md);
        run = r; step = s; speed = sp; mode = md;
        @(posedge clk_25mhz);
        model_clock();
        #1;
        check_outputs();
    endtask

    // Asynchronous reset asserted mid-cycle, checked before the next clock edge
    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_val("async_rst_led", 32'(led), 32'h0);
        check_val("async_rst_pos", 32'(pos_o), 32'h0);
        check_val("async_rst_tick", 32'(tick), 32'h0);
        @(posedge clk_25mhz);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        int ticks_seen;
        int guard;
        logic [N-1:0] bar_tab [4];
        bar_tab[0] = 8'h01; bar_tab[1] = 8'h03; bar_tab[2] = 8'h07; bar_tab[3] = 8'h0F;

        model_reset();
        repeat (2) @(posedge clk_25mhz);
        #1;
        check_val("reset_led", 32'(led), 32'h0);
        check_val("reset_tick", 32'(tick), 32'h0);
        check_val("reset_pos", 32'(pos_o), 32'h0);
        #3 rst_n = 1'b1;

        // bounce, then the two wrap modes
        cycle(1, 0, 0, 0);
        check_val("first_led_onehot", 32'(led), 32'h01);
        repeat (70) cycle(1, 0, 0, 0);
        $display("phase bounce: %0d checks, %0d failures", n_checks, n_fail);
        repeat (40) cycle(1, 0, 0, 1);
        repeat (40) cycle(1, 0, 0, 2);
        guard = 0;
        while (m_pos != 5 && guard < 100) begin cycle(1, 0, 0, 1); guard++; end
        check_val("reach_pos5", 32'(pos_o), 32'd5);
        guard = 0;
        do begin cycle(1, 0, 0, 2); guard++; end while (!m_tick && guard < 100);
        check_val("switch_1to2_pos", 32'(pos_o), 32'd4);
        $display("phase wrap: %0d checks, %0d failures", n_checks, n_fail);

        // bar mode from reset: advances land on cycles 4, 8, 12
        pulse_reset();
        for (int c = 1; c <= 16; c++) begin
            cycle(1, 0, 0, 3);
            if (c % 4 == 2) check_val("bar_led", 32'(led), 32'(bar_tab[c / 4]));
        end
        repeat (60) cycle(1, 0, 0, 3);
        $display("phase bar: %0d checks, %0d failures", n_checks, n_fail);

        // paused single-stepping
        pulse_reset();
        ticks_seen = 0;
        for (int k = 0; k < 3; k++) begin
            cycle(0, 1, 0, 0); ticks_seen += int'(tick);
            cycle(0, 0, 0, 0); ticks_seen += int'(tick);
            cycle(0, 0, 0, 0); ticks_seen += int'(tick);
        end
        check_val("step_ticks", 32'(ticks_seen), 32'd3);
        check_val("step_pos", 32'(pos_o), 32'd3);
        repeat (10) cycle(1, 1, 0, 0);
        $display("phase step: %0d checks, %0d failures", n_checks, n_fail);

        // speed decrease mid-count: cnt reaches 20 with term 31, then term 3
        pulse_reset();
        repeat (20) cycle(1, 0, 3, 0);
        check_val("slow_no_tick", 32'(pos_o), 32'd0);
        cycle(1, 0, 0, 0);
        check_val("speedup_tick", 32'(tick), 32'd1);
        repeat (3) cycle(1, 0, 0, 0);
        check_val("speedup_gap", 32'(tick), 32'd0);
        cycle(1, 0, 0, 0);
        check_val("speedup_period", 32'(tick), 32'd1);
        repeat (15) cycle(1, 0, 0, 0);
        pulse_reset();
        $display("phase speed/reset: %0d checks, %0d failures", n_checks, n_fail);

        // randomized mix
        begin
            logic       r_run;
            logic [2:0] r_speed;
            logic [1:0] r_mode;
            r_run = 1'b1; r_speed = 3'd0; r_mode = 2'd0;
            for (int i = 0; i < 1500; i++) begin
                logic s;
                if ($urandom % 50 == 0) r_mode = 2'($urandom_range(0, 3));
                if ($urandom % 40 == 0)
                    r_speed = ($urandom % 4 == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 1));
                if ($urandom % 60 == 0) r_run = ~r_run;
                s = (r_run ? ($urandom % 4 == 0) : ($urandom % 6 == 0));
                cycle(r_run, s, r_speed, r_mode);
                if (i == 700) pulse_reset();
            end
        end
        $display("phase random: %0d checks, %0d failures", n_checks, n_fail);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_chase_gen.md
Name: led_chase_gen

Overview:
Parametrised LED chase generator driving an N-wide LED bank from a single system clock. It replaces the fixed 8-LED, fixed-rate bounce pattern with:
- selectable pattern mode
- programmable step rate
- run/pause and single-step control
- a per-step tick strobe for other blocks

The whole block runs in the clk_25mhz domain with clock enables; no derived clocks. It sits between the top-level button/switch logic and the led pins.

Parameters:
NUM_LEDS, 8, number of LEDs driven; legal range 2..32.
BASE_SHIFT, 18, log2 of the step period in clk_25mhz cycles at speed=0.
POS_W, $clog2(NUM_LEDS), width of the internal position register.

Ports:
clk_25mhz  input  1  system clock, 25 MHz.
rst_n  input  1  asynchronous active-low reset.
run  input  1  1 = free-running chase; 0 = paused.
step  input  1  single-cycle pulse; advances one position while run=0.
speed  input  3  step period = 2^(BASE_SHIFT+speed) cycles.
mode  input  2  0 bounce, 1 wrap-up, 2 wrap-down, 3 bar-bounce.
led  output  NUM_LEDS  registered LED drive.
tick  output  1  one-cycle pulse on every position advance.
pos_o  output  POS_W  current position, for debug.

Behaviour:
- Reset (rst_n low, async):
  - prescaler cnt=0, pos=0, dir=up.
  - led=0, tick=0, pos_o=0.
- Prescaler:
  - cnt is BASE_SHIFT+8 bits wide; term = 2^(BASE_SHIFT+speed)-1.
  - When run=1: if cnt>=term then cnt<=0 and adv=1; else cnt<=cnt+1.
  - The >= compare lets a speed decrease mid-count wrap on the next cycle, with no long stall.
  - When run=0: cnt holds its value; adv=step.
  - step is ignored while run=1.
- Advance (adv=1), per mode:
  - Bounce (0) and bar-bounce (3):
    - dir=up: if pos==NUM_LEDS-1 then dir<=down, pos<=pos-1; else pos<=pos+1.
    - dir=down: mirror image at pos==0.
    - Period is 2*(NUM_LEDS-1) advances; end LEDs are not repeated.
  - Wrap-up (1): pos<=pos+1, NUM_LEDS-1 wraps to 0; dir forced up.
  - Wrap-down (2): pos<=pos-1, 0 wraps to NUM_LEDS-1; dir forced down.
- Mode change: pos preserved; dir forced as above for modes 1/2; dir kept for modes 0/3. Takes effect at the next advance; the led decode changes on the next cycle.
- Simultaneous adv and mode change: the advance uses the new mode.
- tick: registered copy of adv, i.e. high during the cycle in which pos has just updated.
- led is registered; it reflects the current pos/mode one cycle after pos updates (led latency 1 cycle behind pos).
  - Modes 0-2: led = one-hot, bit pos set.
  - Mode 3: led[i]=1 for all i<=pos.
- First cycle after reset release: led=0 becomes led[0]=1 (one-hot).
- Reset mid-operation clears everything immediately, independent of the clock.

Optional Feature:
Macro LED_CHASE_TRAIL_EN.
- Defined:
  - Adds register prev_pos, loaded with the old pos on each advance; reset 0.
  - In modes 0-2, led[prev_pos] is additionally driven high when cnt[1:0]==0, giving a 25% duty dim trail. This applies only when prev_pos!=pos.
  - Mode 3 is unaffected.
- Undefined: no prev_pos register; led is strictly one-hot in modes 0-2.

Test Plan:
1. NUM_LEDS=8, BASE_SHIFT=2, speed=0, mode=0, run=1:
   - tick every 4 cycles.
   - pos sequence 0,1..7,6..1,0, repeating with period 14 ticks.
   - led follows one-hot, 1 cycle behind pos.
2. mode=1 then mode=2, same settings:
   - pos 7 -> 0 on wrap in mode 1.
   - pos 0 -> 7 in mode 2.
   - Switching 1->2 at pos=5 gives next pos=4.
3. mode=3, pos advancing 0..3:
   - led = 0x01, 0x03, 0x07, 0x0F.
   - At pos=7, led=0xFF; then 0x7F on the way down.
4. run=0, cnt frozen: three step pulses give exactly three ticks and pos 0->3; step with run=1 has no extra effect.
5. speed 3->0 while cnt=20 (term 31 -> 3): advance on the next cycle, then every 4 cycles; rst_n pulsed low mid-chase forces led=0, pos=0 asynchronously.
6. With LED_CHASE_TRAIL_EN, mode=0, pos=3, prev_pos=2:
   - led[2] high exactly 1 of every 4 cycles; led[3] constantly high.
   - Without the macro, led[2] is never high.
